// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX opcode/func constants and encoder enums shared with the decoder
package dlx_pkg;

  localparam logic [5:0] ALU_OP = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQZ   = 6'h04;
  localparam logic [5:0] BNEZ   = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] SUBI   = 6'h0A;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LHI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] FUNC_SLL = 6'h04;
  localparam logic [5:0] FUNC_SRL = 6'h06;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_XOR = 6'h26;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_I    = 3'd1,
    KIND_J    = 3'd2,
    KIND_LI32 = 3'd3,
    KIND_NOP  = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_PEND  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/dlx_field_pack.sv
// rtl/dlx_field_pack.sv - combinational packer from descriptor to one or two DLX words
module dlx_field_pack
  import dlx_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  func_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word0_o,
  output logic [31:0] word1_o,
  output logic        two_words_o,
  output logic        imm_err_o,
  output logic        kind_err_o
);

  always_comb begin
    word0_o     = '0;
    word1_o     = '0;
    two_words_o = 1'b0;
    imm_err_o   = 1'b0;
    kind_err_o  = 1'b0;
    case (kind_e'(kind_i))
      KIND_R: word0_o = {ALU_OP, rs1_i, rs2_i, rd_i, 5'd0, func_i};
      KIND_I: begin
        word0_o   = {opcode_i, rs1_i, rd_i, imm_i[15:0]};
        imm_err_o = !((imm_i[31:16] == 16'h0000) || (imm_i[31:16] == 16'hFFFF));
      end
      KIND_J: begin
        // Offset must sign-extend from bit 25, so bits 31..25 all agree.
        word0_o   = {opcode_i, imm_i[25:0]};
        imm_err_o = !((imm_i[31:25] == 7'h00) || (imm_i[31:25] == 7'h7F));
      end
      KIND_LI32: begin
        word0_o     = {LHI, 5'd0, rd_i, imm_i[31:16]};
        word1_o     = {ORI, rd_i, rd_i, imm_i[15:0]};
        two_words_o = (imm_i[15:0] != 16'h0000);
      end
      KIND_NOP: word0_o = '0;
      default:  kind_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dlx_instr_encoder.sv
// rtl/dlx_instr_encoder.sv - streaming DLX encoder: handshake FSM, output word, address and count
module dlx_instr_encoder
  import dlx_pkg::*;
#(
  parameter int          COUNT_W    = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_kind,
  input  logic [5:0]         in_opcode,
  input  logic [5:0]         in_func,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [4:0]         in_rd,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:31]        out_instr,
  output logic [31:0]        out_addr,
  output logic [COUNT_W-1:0] count,
  output logic               imm_err,
  output logic               kind_err
);

  enc_state_e         state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pend_q, pend_d;
  logic [31:0]        addr_q, addr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               imm_err_q, imm_err_d;
  logic               kind_err_q, kind_err_d;

  logic [31:0] pk_word0, pk_word1;
  logic        pk_two, pk_imm_err, pk_kind_err;
  logic        accept, xfer;

  dlx_field_pack u_pack (
    .kind_i      (in_kind),
    .opcode_i    (in_opcode),
    .func_i      (in_func),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .rd_i        (in_rd),
    .imm_i       (in_imm),
    .word0_o     (pk_word0),
    .word1_o     (pk_word1),
    .two_words_o (pk_two),
    .imm_err_o   (pk_imm_err),
    .kind_err_o  (pk_kind_err)
  );

  assign in_ready  = !start && ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready));
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    count_d    = count_q;
    imm_err_d  = imm_err_q;
    kind_err_d = kind_err_q;

    if (xfer) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + COUNT_W'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (start) begin
          addr_d     = base_addr;
          count_d    = '0;
          imm_err_d  = 1'b0;
          kind_err_d = 1'b0;
        end
      end
      ST_FULL: if (out_ready) state_d = ST_EMPTY;
      ST_PEND: begin
        if (out_ready) begin
          instr_d = pend_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A new descriptor overrides the drain decision above, giving 1 word/cycle.
    if (accept) begin
      instr_d    = pk_word0;
      pend_d     = pk_word1;
      state_d    = pk_two ? ST_PEND : ST_FULL;
      imm_err_d  = imm_err_q | pk_imm_err;
      kind_err_d = kind_err_q | pk_kind_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      instr_q    <= '0;
      pend_q     <= '0;
      addr_q     <= RESET_ADDR;
      count_q    <= '0;
      imm_err_q  <= 1'b0;
      kind_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      imm_err_q  <= imm_err_d;
      kind_err_q <= kind_err_d;
    end
  end

  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign imm_err   = imm_err_q;
  assign kind_err  = kind_err_q;

endmodule

// File: tb/tb_dlx_instr_encoder.sv
// tb/tb_dlx_instr_encoder.sv - randomized scoreboard bench for dlx_instr_encoder
module tb_dlx_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] base_addr, in_imm, out_addr;
  logic [2:0]  in_kind;
  logic [5:0]  in_opcode, in_func;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [0:31] out_instr;
  logic [15:0] count;
  logic        imm_err, kind_err;

  always #5 clk = ~clk;

  dlx_instr_encoder #(.COUNT_W(16), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_opcode(in_opcode), .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count),
    .imm_err(imm_err), .kind_err(kind_err)
  );

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] lit_q[$];
  logic [31:0] m_addr;
  int unsigned m_cnt;
  bit          m_imm_err, m_kind_err;
  bit          acc, toggle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic bit fits_signed(input logic [31:0] v, input int bits);
    longint s, lim;
    s   = longint'($signed(v));
    lim = longint'(1) << (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  // Reference encoding: word = opcode*2^26 + fields at their DLX bit weights.
  task automatic model_accept();
    logic [31:0] op, rs1, rs2, rd, lo;
    op  = 32'(in_opcode) << 26;
    rs1 = 32'(in_rs1);
    rs2 = 32'(in_rs2);
    rd  = 32'(in_rd);
    lo  = in_imm & 32'h0000_FFFF;
    case (in_kind)
      3'd0: exp_q.push_back((rs1 << 21) + (rs2 << 16) + (rd << 11) + 32'(in_func));
      3'd1: begin
        exp_q.push_back(op + (rs1 << 21) + (rd << 16) + lo);
        if (!fits_signed(in_imm, 17)) m_imm_err = 1'b1;
      end
      3'd2: begin
        exp_q.push_back(op + (in_imm & 32'h03FF_FFFF));
        if (!fits_signed(in_imm, 26)) m_imm_err = 1'b1;
      end
      3'd3: begin
        exp_q.push_back(32'h3C00_0000 + (rd << 16) + (in_imm >> 16));
        if (lo != 0) exp_q.push_back(32'h3400_0000 + (rd << 21) + (rd << 16) + lo);
      end
      3'd4: exp_q.push_back(32'h0);
      default: begin
        exp_q.push_back(32'h0);
        m_kind_err = 1'b1;
      end
    endcase
  endtask

  task automatic predict();
    bit exp_rdy, was_empty;
    acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_addr = 32'h0; m_cnt = 0; m_imm_err = 1'b0; m_kind_err = 1'b0;
      return;
    end
    was_empty = (exp_q.size() == 0);
    exp_rdy   = !start && (was_empty || (exp_q.size() == 1 && out_ready));
    chk("in_ready", in_ready, exp_rdy);
    if (!was_empty && out_ready) begin
      if (lit_q.size() != 0) chk("lit_word", out_instr, lit_q.pop_front());
      void'(exp_q.pop_front());
      m_addr += 32'd4;
      m_cnt++;
    end
    if (start && was_empty) begin
      m_addr = base_addr; m_cnt = 0; m_imm_err = 1'b0; m_kind_err = 1'b0;
    end
    if (in_valid && exp_rdy) begin
      acc = 1'b1;
      model_accept();
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_instr", out_instr, exp_q[0]);
    chk("out_addr", out_addr, m_addr);
    chk("count", count, m_cnt & 32'hFFFF);
    chk("imm_err", imm_err, m_imm_err);
    chk("kind_err", kind_err, m_kind_err);
  endtask

  task automatic tick();
    #1 predict();
    @(negedge clk);
    check_outputs();
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [2:0] k, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [31:0] imm);
    int n;
    in_kind = k; in_opcode = op; in_func = fn;
    in_rs1 = r1; in_rs2 = r2; in_rd = d; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0: return 32'($signed($urandom_range(0, 200)) - 100);
      1: return $urandom();
      2: return $urandom() & 32'hFFFF_0000;
      3: begin
        case ($urandom_range(0, 5))
          0: return 32'h0000_FFFF;
          1: return 32'hFFFF_0000;
          2: return 32'h0001_0000;
          3: return 32'h01FF_FFFF;
          4: return 32'hFE00_0000;
          default: return 32'h0200_0000;
        endcase
      end
      default: return $urandom() & 32'h0001_FFFF;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = 3'd0; in_opcode = 6'd0; in_func = 6'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_rd = 5'd0; in_imm = 32'd0; toggle = 1'b0;
    m_addr = 32'h0; m_cnt = 0; m_imm_err = 1'b0; m_kind_err = 1'b0;

    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("lit_reset_addr", out_addr, 32'h0);
    chk("lit_reset_count", count, 32'h0);

    start = 1'b1; base_addr = 32'h100;
    tick();
    start = 1'b0;
    chk("lit_start_addr", out_addr, 32'h100);

    out_ready = 1'b1;
    lit_q.push_back(32'h0022_1820);
    send(3'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h0);
    tick();
    chk("lit_count_r", count, 32'd1);
    chk("lit_addr_r", out_addr, 32'h104);

    lit_q.push_back(32'h2023_0005);
    lit_q.push_back(32'h2023_0000);
    send(3'd1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd3, 32'h0000_0005);
    chk("lit_imm_ok", imm_err, 1'b0);
    send(3'd1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd3, 32'h0001_0000);
    tick(); tick();
    chk("lit_imm_err", imm_err, 1'b1);

    out_ready = 1'b0; toggle = 1'b1;
    lit_q.push_back(32'h3C04_1234);
    lit_q.push_back(32'h3484_5678);
    send(3'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd4, 32'h1234_5678);
    repeat (8) tick();
    toggle = 1'b0; out_ready = 1'b1;

    lit_q.push_back(32'h3C04_ABCD);
    send(3'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd4, 32'hABCD_0000);
    tick(); tick();
    chk("lit_count_li_single", count, 32'd6);

    lit_q.push_back(32'h0BFF_FFFC);
    lit_q.push_back(32'h0);
    lit_q.push_back(32'h0);
    send(3'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    send(3'd4, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    send(3'd4, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (3) tick();
    chk("lit_lits_drained", lit_q.size(), 32'd0);

    out_ready = 1'b0;
    send(3'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd4, 32'h1234_5678);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lit_rst_valid", out_valid, 1'b0);
    chk("lit_rst_count", count, 32'd0);
    chk("lit_rst_addr", out_addr, 32'h0);

    send(3'd4, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    start = 1'b1; base_addr = 32'h200;
    tick();
    start = 1'b0;
    chk("lit_start_ignored", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();

    lit_q.push_back(32'h0);
    send(3'd6, 6'h08, 6'h00, 5'd7, 5'd7, 5'd7, 32'h1234);
    tick(); tick();
    chk("lit_kind_err", kind_err, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 24) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_kind   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      in_opcode = 6'($urandom());
      in_func   = 6'($urandom());
      in_rs1    = 5'($urandom());
      in_rs2    = 5'($urandom());
      in_rd     = 5'($urandom());
      in_imm    = rand_imm();
      tick();
    end

    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
